tlul_reg_responder: RTL and testbench

TL-UL device-side responder that terminates a TL-UL link on the peripheral crossbar side, opposite the host-side request path. It accepts A-channel requests and services them against an internal word register file after a fixed number of wait states. It returns D-channel responses through a small response FIFO. It serves as the standard peripheral endpoint and as the bring-up and verification target behind the peripheral crossbar.

---
 rtl/tlul_reg_responder.sv | 197 +++++++++++++++++++
 tb/tb_tlul_reg_responder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_reg_responder.sv
// tlul_pkg: minimal TL-UL channel structs shared by the responder and its users.
// tlul_reg_responder: TL-UL device endpoint that services A-channel requests against a word
// register file after Latency wait states and queues D-channel responses in a small FIFO.
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   tl_i       host-to-device: A channel plus d_ready
//   tl_o       device-to-host: D channel plus a_ready
//   busy_o     FSM not idle or responses still queued
//   err_cnt_o  saturating count of error responses pushed
package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

module tlul_reg_responder
    import tlul_pkg::*;
#(
    parameter int unsigned NumRegs  = 16,
    parameter int unsigned Latency  = 2,
    parameter int unsigned RspDepth = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  tl_h2d_t    tl_i,
    output tl_d2h_t    tl_o,
    output logic       busy_o,
    output logic [7:0] err_cnt_o
);

    localparam int unsigned AW       = $clog2(NumRegs);
    localparam int unsigned PtrW     = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned CntW     = $clog2(RspDepth + 1);
    localparam bit          ZeroLat  = (Latency == 0);
    localparam logic [3:0]  WaitInit = (Latency > 0) ? 4'(Latency - 1) : 4'd0;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
    } req_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] data;
        logic        error;
    } rsp_t;

    state_e            state_q;
    logic [3:0]        wait_q;
    req_t              req_q;
    logic              ready_q;
    logic [31:0]       regs_q [NumRegs];
    rsp_t              fifo_q [RspDepth];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   cnt_q;
    logic [7:0]        err_cnt_q;

    logic    a_ready, hs, exec_en, pop, err, is_get;
    req_t    req_in, exec_req;
    rsp_t    rsp;
    logic [AW-1:0] idx;

    // ready_q holds a_ready low during reset and through the first edge after release.
    assign a_ready = ready_q && (state_q == StIdle) && (cnt_q < CntW'(RspDepth));
    assign hs      = tl_i.a_valid && a_ready;
    assign pop     = (cnt_q != '0) && tl_i.d_ready;

    assign req_in = '{opcode: tl_i.a_opcode, size: tl_i.a_size, source: tl_i.a_source,
                      address: tl_i.a_address, mask: tl_i.a_mask, data: tl_i.a_data};

    // With zero latency the live A-channel request executes in its handshake cycle.
    assign exec_req = ZeroLat ? req_in : req_q;
    assign exec_en  = ZeroLat ? hs : ((state_q == StWait) && (wait_q == 4'd0));

    assign idx    = exec_req.address[AW+1:2];
    assign is_get = (exec_req.opcode == 3'd4);

    always_comb begin
        err = 1'b0;
        if (!(exec_req.opcode inside {3'd0, 3'd1, 3'd4})) err = 1'b1;
        if (exec_req.address[1:0] != 2'b00)               err = 1'b1;
        if ((exec_req.address >> (AW + 2)) != 32'd0)      err = 1'b1;
        if (exec_req.size > 2'd2)                         err = 1'b1;
        if ((exec_req.opcode == 3'd0) && ((exec_req.size != 2'd2) || (exec_req.mask != 4'hF)))
            err = 1'b1;
    end

    always_comb begin
        rsp        = '0;
        rsp.opcode = is_get ? 3'd1 : 3'd0;
        rsp.size   = exec_req.size;
        rsp.source = exec_req.source;
        rsp.error  = err;
        rsp.data   = (is_get && !err) ? regs_q[idx] : 32'd0;
    end

    // Request FSM: only one request is ever in flight, so a FIFO slot is free at execute.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            wait_q  <= 4'd0;
            req_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            unique case (state_q)
                StIdle: begin
                    if (hs && !ZeroLat) begin
                        state_q <= StWait;
                        wait_q  <= WaitInit;
                        req_q   <= req_in;
                    end
                end
                StWait: begin
                    if (wait_q == 4'd0) state_q <= StIdle;
                    else                wait_q  <= wait_q - 4'd1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NumRegs); i++) regs_q[i] <= '0;
        end else if (exec_en && !err && !is_get) begin
            for (int b = 0; b < 4; b++) begin
                if (exec_req.mask[b]) regs_q[idx][8*b +: 8] <= exec_req.data[8*b +: 8];
            end
        end
    end

    // Payload storage needs no reset: cnt_q gates visibility of every entry.
    always_ff @(posedge clk_i) begin
        if (exec_en) fifo_q[wptr_q] <= rsp;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            err_cnt_q <= 8'd0;
        end else begin
            if (exec_en) wptr_q <= (wptr_q == PtrW'(RspDepth - 1)) ? '0 : wptr_q + 1'b1;
            if (pop)     rptr_q <= (rptr_q == PtrW'(RspDepth - 1)) ? '0 : rptr_q + 1'b1;
            if (exec_en && !pop)      cnt_q <= cnt_q + 1'b1;
            else if (!exec_en && pop) cnt_q <= cnt_q - 1'b1;
            if (exec_en && err && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready;
        tl_o.d_valid  = (cnt_q != '0);
        tl_o.d_opcode = fifo_q[rptr_q].opcode;
        tl_o.d_size   = fifo_q[rptr_q].size;
        tl_o.d_source = fifo_q[rptr_q].source;
        tl_o.d_data   = fifo_q[rptr_q].data;
        tl_o.d_error  = fifo_q[rptr_q].error;
    end

    assign busy_o    = (state_q != StIdle) || (cnt_q != '0);
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_tlul_reg_responder.sv
module tb_tlul_reg_responder;
    import tlul_pkg::*;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    tl_h2d_t    tl_i2, tl_i0;
    tl_d2h_t    tl_o2, tl_o0;
    logic       busy2, busy0;
    logic [7:0] ec2, ec0;

    tlul_reg_responder #(.NumRegs(16), .Latency(2), .RspDepth(2)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .tl_i(tl_i2), .tl_o(tl_o2),
        .busy_o(busy2), .err_cnt_o(ec2)
    );

    tlul_reg_responder #(.NumRegs(16), .Latency(0), .RspDepth(2)) dut0 (
        .clk_i(clk), .rst_ni(rst_ni), .tl_i(tl_i0), .tl_o(tl_o0),
        .busy_o(busy0), .err_cnt_o(ec0)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
        logic [1:0]  size;
        logic [2:0]  e_op;
        logic        e_err;
        logic [31:0] e_data;
        logic [7:0]  e_ec;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] data, input logic [3:0] mask,
                                input logic [1:0] size, input logic [2:0] e_op,
                                input logic e_err, input logic [31:0] e_data,
                                input logic [7:0] e_ec);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.mask = mask; v.size = size;
        v.e_op = e_op; v.e_err = e_err; v.e_data = e_data; v.e_ec = e_ec;
        return v;
    endfunction

    // One full transaction on the Latency=2 instance, response popped at the end.
    task automatic xact2(input vec_t v, input string tag, input logic [7:0] src);
        int t;
        int lows;
        @(negedge clk);
        tl_i2.a_valid = 1'b1; tl_i2.a_opcode = v.op; tl_i2.a_address = v.addr;
        tl_i2.a_data = v.data; tl_i2.a_mask = v.mask; tl_i2.a_size = v.size;
        tl_i2.a_source = src;
        t = 0;
        while (!tl_o2.a_ready && t < 20) begin @(negedge clk); t++; end
        check({tag, " a_ready"}, 32'(tl_o2.a_ready), 32'd1);
        @(posedge clk); #1;
        tl_i2.a_valid = 1'b0;
        @(negedge clk);
        t = 0; lows = 0;
        while (!tl_o2.d_valid && t < 20) begin
            if (!tl_o2.a_ready) lows++;
            @(negedge clk); t++;
        end
        check({tag, " d_valid"}, 32'(tl_o2.d_valid), 32'd1);
        check({tag, " stall cycles"}, 32'(lows), 32'd2);
        check({tag, " d_opcode"}, 32'(tl_o2.d_opcode), 32'(v.e_op));
        check({tag, " d_error"}, 32'(tl_o2.d_error), 32'(v.e_err));
        check({tag, " d_data"}, tl_o2.d_data, v.e_data);
        check({tag, " d_source"}, 32'(tl_o2.d_source), 32'(src));
        check({tag, " d_size"}, 32'(tl_o2.d_size), 32'(v.size));
        check({tag, " err_cnt"}, 32'(ec2), 32'(v.e_ec));
        tl_i2.d_ready = 1'b1;
        @(posedge clk); #1;
        tl_i2.d_ready = 1'b0;
    endtask

    vec_t vecs[18];
    vec_t post[3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int t;
        int hs;
        tl_i2 = '0;
        tl_i0 = '0;

        vecs[0]  = mk(3'd0, 32'h4,        32'hDEADBEEF, 4'hF, 2'd2, 3'd0, 1'b0, 32'h0,        8'd0);
        vecs[1]  = mk(3'd4, 32'h4,        32'h0,        4'hF, 2'd2, 3'd1, 1'b0, 32'hDEADBEEF, 8'd0);
        vecs[2]  = mk(3'd1, 32'h8,        32'h11223344, 4'h5, 2'd2, 3'd0, 1'b0, 32'h0,        8'd0);
        vecs[3]  = mk(3'd4, 32'h8,        32'h0,        4'hF, 2'd2, 3'd1, 1'b0, 32'h00220044, 8'd0);
        vecs[4]  = mk(3'd4, 32'h40,       32'h0,        4'hF, 2'd2, 3'd1, 1'b1, 32'h0,        8'd1);
        vecs[5]  = mk(3'd0, 32'h2,        32'hFFFFFFFF, 4'hF, 2'd2, 3'd0, 1'b1, 32'h0,        8'd2);
        vecs[6]  = mk(3'd2, 32'hC,        32'hFFFFFFFF, 4'hF, 2'd2, 3'd0, 1'b1, 32'h0,        8'd3);
        vecs[7]  = mk(3'd0, 32'hC,        32'hFFFFFFFF, 4'h3, 2'd2, 3'd0, 1'b1, 32'h0,        8'd4);
        vecs[8]  = mk(3'd4, 32'hC,        32'h0,        4'hF, 2'd2, 3'd1, 1'b0, 32'h0,        8'd4);
        vecs[9]  = mk(3'd4, 32'h0,        32'h0,        4'hF, 2'd2, 3'd1, 1'b0, 32'h0,        8'd4);
        vecs[10] = mk(3'd4, 32'h4,        32'h0,        4'hF, 2'd3, 3'd1, 1'b1, 32'h0,        8'd5);
        vecs[11] = mk(3'd1, 32'h4,        32'hAA000000, 4'h8, 2'd2, 3'd0, 1'b0, 32'h0,        8'd5);
        vecs[12] = mk(3'd4, 32'h4,        32'h0,        4'hF, 2'd2, 3'd1, 1'b0, 32'hAAADBEEF, 8'd5);
        vecs[13] = mk(3'd0, 32'h3C,       32'h12345678, 4'hF, 2'd2, 3'd0, 1'b0, 32'h0,        8'd5);
        vecs[14] = mk(3'd4, 32'h3C,       32'h0,        4'hF, 2'd2, 3'd1, 1'b0, 32'h12345678, 8'd5);
        vecs[15] = mk(3'd4, 32'h10000004, 32'h0,        4'hF, 2'd2, 3'd1, 1'b1, 32'h0,        8'd6);
        vecs[16] = mk(3'd1, 32'h8,        32'h0000AB00, 4'h2, 2'd0, 3'd0, 1'b0, 32'h0,        8'd6);
        vecs[17] = mk(3'd4, 32'h8,        32'h0,        4'hF, 2'd2, 3'd1, 1'b0, 32'h0022AB44, 8'd6);

        post[0] = mk(3'd4, 32'h4,  32'h0, 4'hF, 2'd2, 3'd1, 1'b0, 32'h0, 8'd0);
        post[1] = mk(3'd4, 32'h8,  32'h0, 4'hF, 2'd2, 3'd1, 1'b0, 32'h0, 8'd0);
        post[2] = mk(3'd4, 32'h3C, 32'h0, 4'hF, 2'd2, 3'd1, 1'b0, 32'h0, 8'd0);

        // Reset state, with clocks running while held in reset.
        repeat (2) @(negedge clk);
        check("rst a_ready", 32'(tl_o2.a_ready), 32'd0);
        check("rst d_valid", 32'(tl_o2.d_valid), 32'd0);
        check("rst busy", 32'(busy2), 32'd0);
        check("rst err_cnt", 32'(ec2), 32'd0);
        check("rst a_ready lat0", 32'(tl_o0.a_ready), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk);
        check("post-rst a_ready", 32'(tl_o2.a_ready), 32'd1);
        check("post-rst a_ready lat0", 32'(tl_o0.a_ready), 32'd1);

        // Latency=0: FIFO fills with two back-to-back Gets, third waits for a pop.
        tl_i0.a_valid = 1'b1; tl_i0.a_opcode = 3'd4; tl_i0.a_address = 32'h0;
        tl_i0.a_mask = 4'hF; tl_i0.a_size = 2'd2; tl_i0.a_source = 8'd0; tl_i0.d_ready = 1'b0;
        check("l0 accept0", 32'(tl_o0.a_ready), 32'd1);
        @(posedge clk); #1; tl_i0.a_source = 8'd1;
        @(negedge clk);
        check("l0 accept1", 32'(tl_o0.a_ready), 32'd1);
        check("l0 head0 valid", 32'(tl_o0.d_valid), 32'd1);
        check("l0 head0 source", 32'(tl_o0.d_source), 32'd0);
        @(posedge clk); #1; tl_i0.a_source = 8'd2;
        @(negedge clk);
        check("l0 full a_ready", 32'(tl_o0.a_ready), 32'd0);
        check("l0 full busy", 32'(busy0), 32'd1);
        tl_i0.d_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("l0 accept2 after pop", 32'(tl_o0.a_ready), 32'd1);
        check("l0 head1 source", 32'(tl_o0.d_source), 32'd1);
        @(posedge clk); #1; tl_i0.a_valid = 1'b0;
        @(negedge clk);
        check("l0 head2 valid", 32'(tl_o0.d_valid), 32'd1);
        check("l0 head2 source", 32'(tl_o0.d_source), 32'd2);
        check("l0 head2 opcode", 32'(tl_o0.d_opcode), 32'd1);
        check("l0 head2 data", tl_o0.d_data, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("l0 drained", 32'(tl_o0.d_valid), 32'd0);
        tl_i0.d_ready = 1'b0;

        // Table of directed transactions on the Latency=2 instance.
        for (int i = 0; i < 18; i++) begin
            xact2(vecs[i], $sformatf("v%0d", i), 8'(3 + 17 * i));
        end

        // Reset during WAIT with one queued response.
        @(negedge clk);
        tl_i2.a_valid = 1'b1; tl_i2.a_opcode = 3'd4; tl_i2.a_address = 32'h4;
        tl_i2.a_size = 2'd2; tl_i2.a_mask = 4'hF; tl_i2.a_source = 8'h55;
        @(posedge clk); #1; tl_i2.a_valid = 1'b0;
        t = 0;
        while (!tl_o2.d_valid && t < 20) begin @(negedge clk); t++; end
        check("mid queued valid", 32'(tl_o2.d_valid), 32'd1);
        @(negedge clk);
        tl_i2.a_valid = 1'b1; tl_i2.a_opcode = 3'd0; tl_i2.a_address = 32'h8;
        tl_i2.a_data = 32'hCAFEF00D; tl_i2.a_source = 8'h66;
        check("mid second accept", 32'(tl_o2.a_ready), 32'd1);
        @(posedge clk); #1; tl_i2.a_valid = 1'b0;
        check("mid in wait busy", 32'(busy2), 32'd1);
        #1 rst_ni = 1'b0;
        #1;
        check("mid rst d_valid", 32'(tl_o2.d_valid), 32'd0);
        check("mid rst busy", 32'(busy2), 32'd0);
        check("mid rst err_cnt", 32'(ec2), 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk);
        check("mid no stale rsp", 32'(tl_o2.d_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            xact2(post[i], $sformatf("post%0d", i), 8'(i));
        end

        // Saturation on the Latency=0 instance with d_ready held high.
        @(negedge clk);
        tl_i0.d_ready = 1'b1; tl_i0.a_valid = 1'b1; tl_i0.a_opcode = 3'd2;
        tl_i0.a_address = 32'h0;
        hs = 0; t = 0;
        while (hs < 256 && t < 1000) begin
            if (tl_o0.a_ready) hs++;
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        tl_i0.a_valid = 1'b0;
        check("sat handshakes", 32'(hs), 32'd256);
        repeat (3) @(negedge clk);
        check("sat err_cnt", 32'(ec0), 32'd255);
        tl_i0.a_valid = 1'b1;
        repeat (4) @(negedge clk);
        tl_i0.a_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("sat err_cnt hold", 32'(ec0), 32'd255);
        check("sat drained", 32'(tl_o0.d_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
